// File: rtl/uart_tx_fifo_feeder.sv
// Queues received bytes and issues one single-cycle TX request per byte when the transmitter is idle.
// Latency: a push into an empty FIFO with idle TX produces o_tx_dv two edges after i_wr_dv is sampled.
// Backpressure: no new request until the previous frame ends (i_tx_done) or times out; writes into a full FIFO are dropped and flagged.
// Optional macro UART_FIFO_CRLF_EN: a pushed 0x0D also enqueues 0x0A on the same edge (needs two free slots).
module uart_tx_fifo_feeder #(
    parameter int DEPTH          = 16,
    parameter int DATA_W         = 8,
    parameter int ACTIVE_TIMEOUT = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr_dv,
    input  logic [DATA_W-1:0]          i_wr_byte,
    output logic                       o_tx_dv,
    output logic [DATA_W-1:0]          o_tx_byte,
    input  logic                       i_tx_active,
    input  logic                       i_tx_done,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_overflow,
    output logic                       o_tx_err,
    input  logic                       i_clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(ACTIVE_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ACTIVE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_ACTIVE = 2'd1,
        WAIT_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_empty;
    logic                r_full;
    logic                r_overflow;
    logic                r_tx_err;
    logic                r_tx_dv;
    logic [DATA_W-1:0]   r_tx_byte;
    logic [TO_W-1:0]     r_to_cnt;

    logic                w_issue;
    logic                w_to_inc;
    logic                w_timeout;
    logic                w_push1;
    logic                w_push2;
    logic                w_drop;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [PTR_W-1:0]    w_wr_ptr_p1;

    assign w_wr_ptr_p1 = r_wr_ptr + PTR_W'(1);

`ifdef UART_FIFO_CRLF_EN
    localparam logic [CNT_W-1:0] DEPTH_M2 = CNT_W'(DEPTH - 2);

    logic w_is_cr;
    assign w_is_cr = (i_wr_byte == DATA_W'(8'h0D));
    // A CR needs room for itself plus the LF; a same-edge pop does not count as free space.
    assign w_push1 = i_wr_dv && !w_is_cr && !r_full;
    assign w_push2 = i_wr_dv &&  w_is_cr && (r_count <= DEPTH_M2);
    assign w_drop  = i_wr_dv && !w_push1 && !w_push2;
`else
    assign w_push1 = i_wr_dv && !r_full;
    assign w_push2 = 1'b0;
    assign w_drop  = i_wr_dv && r_full;
`endif

    // Occupancy after this edge: +2 / +1 for pushes, -1 for the pop; full check precedes so it never wraps.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push2) begin
            w_count_nxt = w_count_nxt + CNT_W'(2);
        end else if (w_push1) begin
            w_count_nxt = w_count_nxt + CNT_W'(1);
        end
        if (w_issue) begin
            w_count_nxt = w_count_nxt - CNT_W'(1);
        end
    end

    // Next-state and handshake decode for the TX request FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_to_inc    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_empty && !i_tx_active) begin
                    w_issue     = 1'b1;
                    w_state_nxt = WAIT_ACTIVE;
                end
            end
            WAIT_ACTIVE: begin
                if (i_tx_done) begin
                    w_state_nxt = IDLE;
                end else if (i_tx_active) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_to_inc    = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage array; contents need no reset because pointers/count define validity.
    always_ff @(posedge i_clk) begin
        if (w_push1 || w_push2) begin
            r_mem[r_wr_ptr] <= i_wr_byte;
        end
        if (w_push2) begin
            r_mem[w_wr_ptr_p1] <= DATA_W'(8'h0A);
        end
    end

    // Pointers, occupancy flags, TX request/byte, timeout counter and sticky errors.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_tx_dv    <= 1'b0;
            r_tx_byte  <= '0;
            r_to_cnt   <= '0;
            r_overflow <= 1'b0;
            r_tx_err   <= 1'b0;
        end else begin
            if (w_push2) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(2);
            end else if (w_push1) begin
                r_wr_ptr <= w_wr_ptr_p1;
            end

            r_tx_dv <= w_issue;
            if (w_issue) begin
                r_tx_byte <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            end

            if (w_issue) begin
                r_to_cnt <= '0;
            end else if (w_to_inc) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == DEPTH_C);

            // Clear and set on the same edge: set wins.
            r_overflow <= (r_overflow && !i_clr_err) || w_drop;
            r_tx_err   <= (r_tx_err   && !i_clr_err) || w_timeout;
        end
    end

    assign o_tx_dv    = r_tx_dv;
    assign o_tx_byte  = r_tx_byte;
    assign o_count    = r_count;
    assign o_empty    = r_empty;
    assign o_full     = r_full;
    assign o_overflow = r_overflow;
    assign o_tx_err   = r_tx_err;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Directed bench for uart_tx_fifo_feeder: table of per-edge vectors plus multi-cycle sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// A simple TX model raises active the cycle after a request and pulses done after a fixed frame length.
module tb_uart_tx_fifo_feeder;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_wr_dv = 1'b0;
    logic [7:0] i_wr_byte = 8'h00;
    logic       o_tx_dv;
    logic [7:0] o_tx_byte;
    logic       i_tx_active = 1'b0;
    logic       i_tx_done = 1'b0;
    logic [4:0] o_count;
    logic       o_empty;
    logic       o_full;
    logic       o_overflow;
    logic       o_tx_err;
    logic       i_clr_err = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] to_push[$];
    logic [7:0] got[$];
    int         peak;
    int         early;

    uart_tx_fifo_feeder #(.DEPTH(16), .DATA_W(8), .ACTIVE_TIMEOUT(16)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr_dv     (i_wr_dv),
        .i_wr_byte   (i_wr_byte),
        .o_tx_dv     (o_tx_dv),
        .o_tx_byte   (o_tx_byte),
        .i_tx_active (i_tx_active),
        .i_tx_done   (i_tx_done),
        .o_count     (o_count),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
        .o_tx_err    (o_tx_err),
        .i_clr_err   (i_clr_err)
    );

    always #20 i_clk = ~i_clk;

    typedef struct {
        logic       rst_n;
        logic       wr_dv;
        logic [7:0] wr_byte;
        logic       act;
        logic       done;
        logic       clr;
        logic       e_dv;
        logic [7:0] e_byte;
        logic [4:0] e_cnt;
        logic       e_empty;
        logic       e_full;
        logic       e_ovf;
        logic       e_err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0; i_wr_dv = 1'b0; i_tx_active = 1'b0; i_tx_done = 1'b0; i_clr_err = 1'b0;
        step();
        i_rst_n = 1'b1;
    endtask

    // Pushes queued bytes one per cycle while modelling the transmitter.
    task automatic run(input int frame_len, input int cycles);
        int rem;
        rem = 0;
        for (int c = 0; c < cycles; c++) begin
            if (to_push.size() > 0) begin
                i_wr_dv   = 1'b1;
                i_wr_byte = to_push.pop_front();
            end else begin
                i_wr_dv = 1'b0;
            end
            step();
            i_tx_done = 1'b0;
            if (int'(o_count) > peak) peak = int'(o_count);
            if (o_tx_dv) begin
                if (rem > 0 || i_tx_active) early++;
                got.push_back(o_tx_byte);
                i_tx_active = 1'b1;
                rem = frame_len;
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    i_tx_active = 1'b0;
                    i_tx_done   = 1'b1;
                end
            end
        end
        i_wr_dv   = 1'b0;
        i_tx_done = 1'b0;
    endtask

    task automatic check_got(input string name, input logic [7:0] exp[$]);
        check({name, "_len"}, got.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            check($sformatf("%s_b%0d", name, k), {24'h0, got[k]}, {24'h0, exp[k]});
        end
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int         dv_seen;

        //           rst  wr   byte   act  done clr | dv  byte   cnt emp full ovf err
        vecs[0]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b0,8'h00,5'd0,1'b1,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b1,8'h41,1'b0,1'b0,1'b0, 1'b0,8'h00,5'd1,1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,8'h41,5'd0,1'b1,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b0,8'h00,1'b1,1'b0,1'b0, 1'b0,8'h41,5'd0,1'b1,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b1,8'h42,1'b1,1'b0,1'b0, 1'b0,8'h41,5'd1,1'b0,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b0,8'h00,1'b1,1'b1,1'b0, 1'b0,8'h41,5'd1,1'b0,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,8'h42,5'd0,1'b1,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b0,8'h00,1'b0,1'b1,1'b0, 1'b0,8'h42,5'd0,1'b1,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b1,8'h43,1'b0,1'b0,1'b0, 1'b0,8'h42,5'd1,1'b0,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b1,8'h44,1'b0,1'b0,1'b0, 1'b1,8'h43,5'd1,1'b0,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b0,8'h00,1'b1,1'b0,1'b0, 1'b0,8'h43,5'd1,1'b0,1'b0,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b0,8'h00,1'b1,1'b0,1'b1, 1'b0,8'h43,5'd1,1'b0,1'b0,1'b0,1'b0};
        vecs[12] = '{1'b1,1'b0,8'h00,1'b0,1'b1,1'b0, 1'b0,8'h43,5'd1,1'b0,1'b0,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0, 1'b1,8'h44,5'd0,1'b1,1'b0,1'b0,1'b0};
        vecs[14] = '{1'b1,1'b0,8'h00,1'b0,1'b1,1'b0, 1'b0,8'h44,5'd0,1'b1,1'b0,1'b0,1'b0};

        #1;
        for (int v = 0; v < NV; v++) begin
            i_rst_n     = vecs[v].rst_n;
            i_wr_dv     = vecs[v].wr_dv;
            i_wr_byte   = vecs[v].wr_byte;
            i_tx_active = vecs[v].act;
            i_tx_done   = vecs[v].done;
            i_clr_err   = vecs[v].clr;
            step();
            check($sformatf("vec%0d", v),
                  {14'h0, o_tx_dv, o_tx_byte, o_count, o_empty, o_full, o_overflow, o_tx_err},
                  {14'h0, vecs[v].e_dv, vecs[v].e_byte, vecs[v].e_cnt, vecs[v].e_empty,
                   vecs[v].e_full, vecs[v].e_ovf, vecs[v].e_err});
        end

        // Burst of 5 against long frames: in order, never early, peak occupancy 4.
        do_reset();
        got.delete(); peak = 0; early = 0;
        to_push = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        run(20, 150);
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        check_got("burst", exp_q);
        check("burst_early", early, 0);
        check("burst_peak", peak, 4);
        check("burst_empty", {31'h0, o_empty}, 32'h1);

        // Handshake timeout: error after exactly ACTIVE_TIMEOUT cycles, then next byte served.
        do_reset();
        i_wr_dv = 1'b1; i_wr_byte = 8'h55; step();
        i_wr_byte = 8'h66; step();
        i_wr_dv = 1'b0;
        check("to_req1", {23'h0, o_tx_dv, o_tx_byte}, {23'h0, 1'b1, 8'h55});
        for (int k = 1; k < 16; k++) step();
        check("to_err_early", {30'h0, o_tx_dv, o_tx_err}, 32'h0);
        step();
        check("to_err_set", {31'h0, o_tx_err}, 32'h1);
        step();
        check("to_req2", {23'h0, o_tx_dv, o_tx_byte}, {23'h0, 1'b1, 8'h66});
        i_tx_active = 1'b1; i_clr_err = 1'b1; step();
        i_clr_err = 1'b0;
        check("to_err_clr", {31'h0, o_tx_err}, 32'h0);
        i_tx_active = 1'b0; i_tx_done = 1'b1; step();
        i_tx_done = 1'b0;

        // Overflow with TX stalled: 19 pushes keep the first 16.
        do_reset();
        i_tx_active = 1'b1;
        for (int k = 0; k < 19; k++) begin
            i_wr_dv = 1'b1; i_wr_byte = 8'h80 + 8'(k); step();
        end
        i_wr_dv = 1'b0;
        check("ovf_state", {27'h0, o_count, o_full, o_overflow}, {27'h0, 5'd16, 1'b1, 1'b1});
        i_tx_active = 1'b0;
        got.delete(); peak = 0; early = 0;
        run(3, 120);
        exp_q.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back(8'h80 + 8'(k));
        check_got("ovf_drain", exp_q);
        check("ovf_sticky", {30'h0, o_empty, o_overflow}, 32'h3);
        i_clr_err = 1'b1; step();
        i_clr_err = 1'b0;
        check("ovf_clr", {31'h0, o_overflow}, 32'h0);

        // Reset while a frame is in flight with 3 bytes queued.
        do_reset();
        i_wr_dv = 1'b1; i_wr_byte = 8'h11; step();
        i_wr_byte = 8'h12; step();
        i_wr_byte = 8'h13; i_tx_active = 1'b1; step();
        i_wr_byte = 8'h14; step();
        i_wr_dv = 1'b0;
        check("rst_pre_cnt", {27'h0, o_count}, 32'd3);
        i_rst_n = 1'b0; step();
        check("rst_state", {25'h0, o_count, o_empty, o_tx_dv}, {25'h0, 5'd0, 1'b1, 1'b0});
        i_rst_n = 1'b1;
        i_tx_active = 1'b0; i_tx_done = 1'b1; step();
        i_tx_done = 1'b0;
        dv_seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (o_tx_dv) dv_seen++;
        end
        check("rst_no_stale", dv_seen, 0);

`ifdef UART_FIFO_CRLF_EN
        // CR with two free slots expands to CR LF; with one free slot both are dropped.
        do_reset();
        i_tx_active = 1'b1;
        for (int k = 0; k < 14; k++) begin
            i_wr_dv = 1'b1; i_wr_byte = 8'h20 + 8'(k); step();
        end
        i_wr_byte = 8'h0D; step();
        i_wr_dv = 1'b0;
        check("crlf_fill", {26'h0, o_count, o_full}, {26'h0, 5'd16, 1'b1});
        i_tx_active = 1'b0;
        got.delete(); peak = 0; early = 0;
        run(3, 120);
        exp_q.delete();
        for (int k = 0; k < 14; k++) exp_q.push_back(8'h20 + 8'(k));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        check_got("crlf_order", exp_q);
        do_reset();
        i_tx_active = 1'b1;
        for (int k = 0; k < 15; k++) begin
            i_wr_dv = 1'b1; i_wr_byte = 8'h20 + 8'(k); step();
        end
        i_wr_byte = 8'h0D; step();
        i_wr_dv = 1'b0;
        check("crlf_drop", {26'h0, o_count, o_overflow}, {26'h0, 5'd15, 1'b1});
`else
        // Without CR/LF expansion a CR is an ordinary single entry.
        do_reset();
        i_tx_active = 1'b1;
        i_wr_dv = 1'b1; i_wr_byte = 8'h0D; step();
        i_wr_dv = 1'b0;
        check("cr_plain", {26'h0, o_count, o_overflow}, {26'h0, 5'd1, 1'b0});
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
